// File: rtl/d2l_pkg.sv
// Shared definitions for the D2L serial link: controller states, default
// lane geometry and the counter width helper used by master and receiver.
package d2l_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2
    } d2l_state_e;

    localparam int DEF_LANES   = 2;
    localparam int DEF_LANE_W  = 4;
    localparam int DEF_BEATS   = 4;
    localparam int DEF_BEAT_W  = DEF_LANES * DEF_LANE_W;
    localparam int DEF_FRAME_W = DEF_BEAT_W * DEF_BEATS;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int beat_width(input int lanes, input int lane_w);
        return lanes * lane_w;
    endfunction

endpackage

// File: rtl/d2l_half_div.sv
// Half-period counter: counts 0..HALF_DIV-1 while enabled and flags the last
// count with a tick. Clear has priority over enable.
module d2l_half_div
    import d2l_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = clog2_min1(HALF_DIV);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/d2l_tx_master.sv
// Multi-lane D2L transmit master: captures one frame per valid/ready handshake
// and shifts it out as BEATS beats across LANES lanes under cs_n and sclk.
module d2l_tx_master
    import d2l_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int LANE_W   = DEF_LANE_W,
    parameter int BEATS    = DEF_BEATS,
    parameter int HALF_DIV = 4,
    parameter bit CPOL     = 1'b0
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [LANES*LANE_W*BEATS-1:0]   tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            sclk,
    output logic                            cs_n,
    output logic [LANES*LANE_W-1:0]         dl,
    output logic                            done
);

    localparam int BEAT_W  = beat_width(LANES, LANE_W);
    localparam int FRAME_W = BEAT_W * BEATS;
    localparam int BW      = clog2_min1(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    d2l_state_e        state, state_nxt;
    logic [FRAME_W-1:0] frame;
    logic [BW-1:0]     beat, beat_nxt, beat_inc;
    logic              phase, phase_nxt;
    logic              sclk_nxt, cs_n_nxt, ready_nxt, done_nxt;
    logic [BEAT_W-1:0] dl_nxt;
    logic              capture;
    logic              tick;
    logic              hd_en, hd_clr;

    logic [BEAT_W-1:0] slice [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_slice
        assign slice[g] = frame[g*BEAT_W +: BEAT_W];
    end

    assign beat_inc = beat + 1'b1;
    assign hd_en    = (state != IDLE);
    assign hd_clr   = (state == IDLE);

    d2l_half_div #(
        .HALF_DIV (HALF_DIV)
    ) u_half_div (
        .clk  (clk),
        .rstn (rstn),
        .en   (hd_en),
        .clr  (hd_clr),
        .tick (tick)
    );

    // phase 0 = active half (sclk away from CPOL), phase 1 = return half.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        phase_nxt = phase;
        sclk_nxt  = sclk;
        cs_n_nxt  = cs_n;
        dl_nxt    = dl;
        ready_nxt = tx_ready;
        done_nxt  = 1'b0;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    capture   = 1'b1;
                    state_nxt = SETUP;
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = CPOL;
                    dl_nxt    = tx_data[BEAT_W-1:0];
                    ready_nxt = 1'b0;
                    beat_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end

            SETUP: begin
                if (tick) begin
                    state_nxt = SHIFT;
                    sclk_nxt  = ~CPOL;
                    phase_nxt = 1'b0;
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (!phase) begin
                        phase_nxt = 1'b1;
                        sclk_nxt  = CPOL;
                        // Last beat keeps its value through the hold half.
                        if (beat != LAST_BEAT) begin
                            dl_nxt = slice[beat_inc];
                        end
                    end else if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                        cs_n_nxt  = 1'b1;
                        dl_nxt    = '0;
                        ready_nxt = 1'b1;
                        done_nxt  = 1'b1;
                        beat_nxt  = '0;
                        phase_nxt = 1'b0;
                    end else begin
                        beat_nxt  = beat_inc;
                        phase_nxt = 1'b0;
                        sclk_nxt  = ~CPOL;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                sclk_nxt  = CPOL;
                dl_nxt    = '0;
                ready_nxt = 1'b1;
                beat_nxt  = '0;
                phase_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat     <= '0;
            phase    <= 1'b0;
            sclk     <= CPOL;
            cs_n     <= 1'b1;
            dl       <= '0;
            tx_ready <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            phase    <= phase_nxt;
            sclk     <= sclk_nxt;
            cs_n     <= cs_n_nxt;
            dl       <= dl_nxt;
            tx_ready <= ready_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame <= '0;
        end else if (capture) begin
            frame <= tx_data;
        end
    end

endmodule

// File: tb/tb_d2l_tx_master.sv
// Directed bench for d2l_tx_master: default instance plus a 4-lane, HALF_DIV=1,
// CPOL=1 instance, checked through a beat/done scoreboard.
module tb_d2l_tx_master;

    localparam int A_HALF = 4;
    localparam int A_BEATS = 4;
    localparam int A_LOW  = A_HALF * (2*A_BEATS + 1);
    localparam int B_HALF = 1;
    localparam int B_BEATS = 3;
    localparam int B_LOW  = B_HALF * (2*B_BEATS + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [31:0] a_data;
    logic        a_valid, a_ready, a_sclk, a_cs_n, a_done;
    logic [7:0]  a_dl;
    logic [23:0] b_data;
    logic        b_valid, b_ready, b_sclk, b_cs_n, b_done;
    logic [7:0]  b_dl;

    d2l_tx_master dut_a (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (a_data),
        .tx_valid (a_valid),
        .tx_ready (a_ready),
        .sclk     (a_sclk),
        .cs_n     (a_cs_n),
        .dl       (a_dl),
        .done     (a_done)
    );

    d2l_tx_master #(
        .LANES(4), .LANE_W(2), .BEATS(3), .HALF_DIV(1), .CPOL(1'b1)
    ) dut_b (
        .clk      (clk),
        .rstn     (rstn),
        .tx_data  (b_data),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .sclk     (b_sclk),
        .cs_n     (b_cs_n),
        .dl       (b_dl),
        .done     (b_done)
    );

    typedef struct {
        logic [7:0] dl;
        int         cyc;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    int    qa_done[$];
    int    qb_done[$];

    int cyc = 0;
    int passed = 0;
    int total = 0;
    logic a_psclk = 1'b0;
    logic b_psclk = 1'b1;
    int a_low = 0, a_high = 0, a_last_high = 0;
    int b_low = 0;
    int a_done_last = 0, a_done_prev = 0;
    bit a_abort = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: register handshakes, advance, then observe #1 after the edge.
    task automatic step();
        logic        a_hs, b_hs;
        logic [31:0] a_cap;
        logic [23:0] b_cap;
        beat_t       e;
        int          d;
        a_hs  = a_valid && a_ready && rstn;
        b_hs  = b_valid && b_ready && rstn;
        a_cap = a_data;
        b_cap = b_data;
        @(posedge clk);
        cyc++;
        #1;
        if (a_hs) begin
            for (int b = 0; b < A_BEATS; b++)
                qa.push_back('{a_cap[b*8 +: 8], cyc + A_HALF + 2*A_HALF*b});
            qa_done.push_back(cyc + A_LOW);
            check("a_setup_dl", a_dl, a_cap[7:0]);
            check("a_setup_csn", a_cs_n, 1'b0);
            check("a_setup_ready", a_ready, 1'b0);
        end
        if (b_hs) begin
            for (int b = 0; b < B_BEATS; b++)
                qb.push_back('{b_cap[b*8 +: 8], cyc + B_HALF + 2*B_HALF*b});
            qb_done.push_back(cyc + B_LOW);
            check("b_setup_dl", b_dl, b_cap[7:0]);
            check("b_setup_csn", b_cs_n, 1'b0);
        end
        if (!a_psclk && a_sclk) begin
            if (qa.size() == 0) check("a_beat_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_beat_dl", a_dl, e.dl);
                check("a_beat_cyc", cyc, e.cyc);
            end
        end
        if (b_psclk && !b_sclk) begin
            if (qb.size() == 0) check("b_beat_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_beat_dl", b_dl, e.dl);
                check("b_beat_cyc", cyc, e.cyc);
            end
        end
        if (a_done) begin
            if (qa_done.size() == 0) check("a_done_unexpected", 1, 0);
            else begin
                d = qa_done.pop_front();
                check("a_done_cyc", cyc, d);
                check("a_done_csn", a_cs_n, 1'b1);
                check("a_done_dl", a_dl, 8'h00);
                check("a_done_ready", a_ready, 1'b1);
            end
            a_done_prev = a_done_last;
            a_done_last = cyc;
        end
        if (b_done) begin
            if (qb_done.size() == 0) check("b_done_unexpected", 1, 0);
            else begin
                d = qb_done.pop_front();
                check("b_done_cyc", cyc, d);
            end
        end
        if (!a_cs_n) begin
            if (a_low == 0) a_last_high = a_high;
            a_low++;
            a_high = 0;
        end else begin
            if (a_low != 0 && !a_abort) check("a_csn_low_len", a_low, A_LOW);
            a_low = 0;
            a_high++;
        end
        if (!b_cs_n) b_low++;
        else begin
            if (b_low != 0) check("b_csn_low_len", b_low, B_LOW);
            b_low = 0;
        end
        a_psclk = a_sclk;
        b_psclk = b_sclk;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(a_ready && b_ready && qa.size() == 0 && qb.size() == 0 &&
                     qa_done.size() == 0 && qb_done.size() == 0) && n < budget);
        if (n >= budget) check("idle_timeout", 0, 1);
    endtask

    initial begin
        rstn    = 1'b0;
        a_data  = '0;
        a_valid = 1'b0;
        b_data  = '0;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_a_sclk", a_sclk, 1'b0);
        check("rst_a_csn", a_cs_n, 1'b1);
        check("rst_a_dl", a_dl, 8'h00);
        check("rst_a_done", a_done, 1'b0);
        check("rst_b_sclk", b_sclk, 1'b1);
        check("rst_b_csn", b_cs_n, 1'b1);
        rstn = 1'b1;
        repeat (2) step();

        // Single default frame.
        a_data  = 32'h8765_4321;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        run_until_idle(100);

        // Back-to-back frames with tx_valid held high.
        a_data  = 32'hAAAA_AAAA;
        a_valid = 1'b1;
        step();
        a_data = 32'h5555_5555;
        for (int n = 0; n < 60; n++) begin
            step();
            if (a_done) break;
        end
        check("b2b_first_done", a_done, 1'b1);
        step();
        a_valid = 1'b0;
        check("b2b_csn_high_len", a_last_high, 1);
        check("b2b_second_dl", a_dl, 8'h55);
        run_until_idle(100);
        check("b2b_done_spacing", a_done_last - a_done_prev, A_LOW + 1);

        // Reset in the middle of a frame.
        a_data  = 32'h0F1E_2D3C;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        repeat (14) step();
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_csn", a_cs_n, 1'b1);
        check("mid_rst_sclk", a_sclk, 1'b0);
        check("mid_rst_dl", a_dl, 8'h00);
        check("mid_rst_ready", a_ready, 1'b1);
        check("mid_rst_done", a_done, 1'b0);
        qa.delete();
        qa_done.delete();
        a_abort = 1'b1;
        a_psclk = a_sclk;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_done", a_done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        a_abort = 1'b0;
        a_data  = 32'hC3B2_A190;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        run_until_idle(100);

        // tx_valid pulsed with different data while busy.
        a_data  = 32'h1357_9BDF;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        repeat (10) step();
        check("busy_ready_low", a_ready, 1'b0);
        a_data  = 32'hFFFF_FFFF;
        a_valid = 1'b1;
        repeat (5) step();
        a_valid = 1'b0;
        run_until_idle(100);
        repeat (5) step();
        check("busy_no_second_frame", a_cs_n, 1'b1);

        // tx_data churns after the handshake.
        a_data  = 32'h2468_ACE1;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 36; i++) begin
            a_data = $urandom;
            step();
        end
        run_until_idle(100);

        // Four lanes, HALF_DIV=1, CPOL=1.
        b_data  = 24'hE4_1BC6;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        check("b_sclk_t1", b_sclk, 1'b1);
        for (int t = 2; t <= 7; t++) begin
            step();
            check("b_sclk_toggle", b_sclk, (t % 2 == 0) ? 1'b0 : 1'b1);
        end
        run_until_idle(20);
        check("b_idle_sclk", b_sclk, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
